// File: rtl/alu_ops_pkg.sv
// Shared ALU definitions: flag bit positions and the result record
// handed from the ALU to its writeback stage.
package alu_ops;

  localparam int unsigned ALU_W  = 3;

  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef struct packed {
    logic [ALU_W-1:0] y;
    logic [3:0]       flags;
    logic             set_flags;
  } alu_result_t;

endpackage

// File: rtl/alu_skid_buffer.sv
// Generic 2-entry valid/ready buffer. in_ready, out_valid and out_data all come
// straight from registers, so there is no combinational path between the two sides.
module alu_skid_buffer #(
  parameter int unsigned PW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  logic [1:0]    count_q, count_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          accept_s, pop_s;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = head_q;

  // Occupancy update; in_data is only sampled on accept so idle X never reaches state.
  always_comb begin
    count_d  = count_q;
    head_d   = head_q;
    tail_d   = tail_q;
    accept_s = in_valid & in_ready_q;
    pop_s    = out_valid_q & out_ready;
    case (count_q)
      2'd0: begin
        if (accept_s) begin
          head_d  = in_data;
          count_d = 2'd1;
        end else begin
          count_d = 2'd0;
        end
      end
      2'd1: begin
        if (accept_s && pop_s) begin
          head_d  = in_data;
          count_d = 2'd1;
        end else if (accept_s) begin
          tail_d  = in_data;
          count_d = 2'd2;
        end else if (pop_s) begin
          count_d = 2'd0;
        end else begin
          count_d = 2'd1;
        end
      end
      2'd2: begin
        if (pop_s) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end else begin
          count_d = 2'd2;
        end
      end
      default: begin
        count_d = 2'd0;
      end
    endcase
    in_ready_d  = (count_d != 2'd2);
    out_valid_d = (count_d != 2'd0);
  end

  // Buffer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= 2'd0;
      head_q      <= '0;
      tail_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: rtl/alu_wb_stage.sv
// ALU writeback stage: buffers results in order and, as each one retires,
// updates the NZCV status, the sticky overflow bit and the retire counter.
module alu_wb_stage
  import alu_ops::*;
#(
  parameter int unsigned W     = 3,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_y,
  input  logic [3:0]       in_flags,
  input  logic             in_set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_y,
  output logic [3:0]       out_flags,
  output logic [3:0]       status,
  output logic             sticky_v,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] retire_cnt
);

  typedef struct packed {
    logic [W-1:0] y;
    logic [3:0]   flags;
    logic         set_flags;
  } entry_t;

  entry_t           in_ent_s, head_s;
  logic             pop_s;
  logic [3:0]       status_q, status_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign in_ent_s = '{y: in_y, flags: in_flags, set_flags: in_set_flags};

  alu_skid_buffer #(
    .PW($bits(entry_t))
  ) u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_ent_s),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (head_s)
  );

  assign out_y      = head_s.y;
  assign out_flags  = head_s.flags;
  assign status     = status_q;
  assign sticky_v   = sticky_q;
  assign retire_cnt = cnt_q;

  // Retire side effects act on the head entry as it leaves; a set beats a clear.
  always_comb begin
    pop_s    = out_valid & out_ready;
    status_d = status_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (pop_s) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (head_s.set_flags) begin
        status_d = head_s.flags;
      end else begin
        status_d = status_q;
      end
      if (head_s.flags[FLAG_V]) begin
        sticky_d = 1'b1;
      end else if (clr_sticky) begin
        sticky_d = 1'b0;
      end else begin
        sticky_d = sticky_q;
      end
    end else if (clr_sticky) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // Architectural status, sticky and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_q <= 4'b0000;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      status_q <= status_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_alu_wb_stage.sv
// Bench for alu_wb_stage: directed scenarios plus random traffic, checked
// against a queue-based model of the stage's retire behaviour.
module tb_alu_wb_stage;

  localparam int W     = 3;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_y = '0;
  logic [3:0]       in_flags = '0;
  logic             in_set_flags = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [W-1:0]     out_y;
  logic [3:0]       out_flags;
  logic [3:0]       status;
  logic             sticky_v;
  logic             clr_sticky = 1'b0;
  logic [CNT_W-1:0] retire_cnt;

  alu_wb_stage #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_y(in_y),
    .in_flags(in_flags), .in_set_flags(in_set_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_flags(out_flags), .status(status), .sticky_v(sticky_v),
    .clr_sticky(clr_sticky), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] y;
    logic [3:0]   f;
    logic         s;
  } ent_t;

  ent_t       mq[$];
  logic [3:0] m_status = 4'b0000;
  logic       m_sticky = 1'b0;
  int         m_cnt = 0;
  int         total = 0;
  int         bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string ctx);
    chk({ctx, ".out_valid"}, 32'(out_valid), 32'(mq.size() != 0));
    chk({ctx, ".in_ready"},  32'(in_ready),  32'(mq.size() < 2));
    if (mq.size() != 0) begin
      chk({ctx, ".out_y"},     32'(out_y),     32'(mq[0].y));
      chk({ctx, ".out_flags"}, 32'(out_flags), 32'(mq[0].f));
    end
    chk({ctx, ".status"},     32'(status),     32'(m_status));
    chk({ctx, ".sticky_v"},   32'(sticky_v),   32'(m_sticky));
    chk({ctx, ".retire_cnt"}, 32'(retire_cnt), 32'(m_cnt));
  endtask

  // One clock with the inputs already applied: advance the model, then check.
  task automatic step(input string ctx);
    bit   acc, pp;
    ent_t e, nin;
    acc = in_valid && (mq.size() < 2);
    pp  = (mq.size() > 0) && out_ready;
    nin = '{in_y, in_flags, in_set_flags};
    @(posedge clk);
    if (pp) begin
      e = mq.pop_front();
      if (e.s) m_status = e.f;
      m_sticky = e.f[2] ? 1'b1 : (clr_sticky ? 1'b0 : m_sticky);
      m_cnt = (m_cnt + 1) % (1 << CNT_W);
    end else if (clr_sticky) begin
      m_sticky = 1'b0;
    end
    if (acc) mq.push_back(nin);
    @(negedge clk);
    compare_all(ctx);
  endtask

  task automatic drive(input string ctx, input bit v, input logic [W-1:0] y, input logic [3:0] f,
                       input bit s, input bit ordy, input bit clr);
    in_valid = v; in_y = y; in_flags = f; in_set_flags = s;
    out_ready = ordy; clr_sticky = clr;
    step(ctx);
  endtask

  task automatic model_reset();
    mq.delete();
    m_status = 4'b0000;
    m_sticky = 1'b0;
    m_cnt = 0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    chk("rst.out_y", 32'(out_y), 32'd0);
    chk("rst.out_flags", 32'(out_flags), 32'd0);
    compare_all("rst");
    rst_n = 1'b1;
  endtask

  int   wrap_exp[5] = '{1, 2, 3, 0, 1};
  bit   hold;
  bit   will_acc;

  initial begin
    @(negedge clk);
    do_reset();

    // single transfer
    drive("single.push", 1'b1, 3'b101, 4'b0010, 1'b1, 1'b1, 1'b0);
    chk("single.valid", 32'(out_valid), 32'd1);
    chk("single.y", 32'(out_y), 32'd5);
    chk("single.flags", 32'(out_flags), 32'd2);
    drive("single.pop", 1'b0, 3'b000, 4'b0000, 1'b0, 1'b1, 1'b0);
    chk("single.status", 32'(status), 32'b0010);
    chk("single.cnt", 32'(retire_cnt), 32'd1);

    // backpressure
    drive("bp.p1", 1'b1, 3'd1, 4'b0000, 1'b0, 1'b0, 1'b0);
    drive("bp.p2", 1'b1, 3'd2, 4'b0000, 1'b0, 1'b0, 1'b0);
    chk("bp.full", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      drive("bp.hold", 1'b1, 3'd3, 4'b0000, 1'b0, 1'b0, 1'b0);
      chk("bp.not_taken", 32'(in_ready), 32'd0);
    end
    chk("bp.order1", 32'(out_y), 32'd1);
    drive("bp.pop1", 1'b1, 3'd3, 4'b0000, 1'b0, 1'b1, 1'b0);
    chk("bp.ready_back", 32'(in_ready), 32'd1);
    chk("bp.order2", 32'(out_y), 32'd2);
    drive("bp.pop2", 1'b1, 3'd3, 4'b0000, 1'b0, 1'b1, 1'b0);
    chk("bp.order3", 32'(out_y), 32'd3);
    drive("bp.pop3", 1'b0, 3'd0, 4'b0000, 1'b0, 1'b1, 1'b0);

    // streaming at count 1
    drive("st.a", 1'b1, 3'd4, 4'b0001, 1'b0, 1'b1, 1'b0);
    chk("st.y4", 32'(out_y), 32'd4);
    drive("st.b", 1'b1, 3'd6, 4'b0001, 1'b0, 1'b1, 1'b0);
    chk("st.y6", 32'(out_y), 32'd6);
    chk("st.ready6", 32'(in_ready), 32'd1);
    drive("st.c", 1'b1, 3'd7, 4'b0001, 1'b0, 1'b1, 1'b0);
    chk("st.y7", 32'(out_y), 32'd7);
    chk("st.ready7", 32'(in_ready), 32'd1);
    drive("st.d", 1'b0, 3'd0, 4'b0000, 1'b0, 1'b1, 1'b0);

    // set_flags=0, sticky set/clear priority
    drive("sk.push", 1'b1, 3'd0, 4'b1111, 1'b0, 1'b0, 1'b0);
    drive("sk.pop", 1'b0, 3'd0, 4'b0000, 1'b0, 1'b1, 1'b0);
    chk("sk.set", 32'(sticky_v), 32'd1);
    drive("sk.push2", 1'b1, 3'd2, 4'b0100, 1'b0, 1'b0, 1'b0);
    drive("sk.popclr", 1'b0, 3'd0, 4'b0000, 1'b0, 1'b1, 1'b1);
    chk("sk.setwins", 32'(sticky_v), 32'd1);
    drive("sk.clr", 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0, 1'b1);
    chk("sk.cleared", 32'(sticky_v), 32'd0);

    // counter wrap
    do_reset();
    drive("wrap.push", 1'b1, 3'd1, 4'b0000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive("wrap", (i < 4), 3'(i + 2), 4'b0000, 1'b0, 1'b1, 1'b0);
      chk("wrap.cnt", 32'(retire_cnt), 32'(wrap_exp[i]));
    end

    // random traffic, with upstream holding stalled values
    hold = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        in_valid = ($urandom % 4) != 0;
        in_y = in_valid ? W'($urandom) : 'x;
        in_flags = in_valid ? 4'($urandom) : 'x;
        in_set_flags = in_valid ? 1'($urandom) : 'x;
      end
      out_ready = ($urandom % 3) != 0;
      clr_sticky = ($urandom % 8) == 0;
      will_acc = mq.size() < 2;
      step("rnd");
      hold = in_valid && !will_acc;
    end

    // asynchronous reset with two entries held
    drive("ar.p1", 1'b1, 3'd5, 4'b1010, 1'b1, 1'b0, 1'b0);
    drive("ar.p2", 1'b1, 3'd6, 4'b0110, 1'b1, 1'b0, 1'b0);
    drive("ar.pop", 1'b1, 3'd3, 4'b1100, 1'b1, 1'b1, 1'b0);
    drive("ar.fill", 1'b1, 3'd2, 4'b0101, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.out_valid", 32'(out_valid), 32'd0);
    chk("ar.in_ready", 32'(in_ready), 32'd1);
    chk("ar.status", 32'(status), 32'd0);
    chk("ar.retire_cnt", 32'(retire_cnt), 32'd0);
    chk("ar.sticky_v", 32'(sticky_v), 32'd0);
    model_reset();
    @(negedge clk);
    compare_all("ar.held");
    rst_n = 1'b1;
    drive("ar.after", 1'b1, 3'd4, 4'b0011, 1'b1, 1'b1, 1'b0);
    drive("ar.after2", 1'b0, 3'd0, 4'b0000, 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
